// File: rtl/ifetch_align.sv
// Instruction fetch aligner: turns a byte PC into one 16/32-bit RISC-V instruction,
// issuing one or two word reads and stitching halfwords that straddle a word boundary.
module ifetch_align #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_LAT_MAX = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_ready,
  input  logic            flush,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_rvc,
  output logic            inst_misalign
);

  localparam int unsigned HW_W   = 16;
  localparam int unsigned WORD_W = 32;

  // Memory latency is unbounded; the parameter only records an expected figure.
  if (MEM_LAT_MAX > 0) begin : g_lat_doc
  end

  typedef enum logic [2:0] {IDLE, LO, HI, HOLD, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [HW_W-1:0]     hw_q, hw_d;
  logic                req_q, req_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [WORD_W-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]     ipc_q, ipc_d;
  logic                rvc_q, rvc_d;
  logic                mis_q, mis_d;
  logic [HW_W-1:0]     sel_hw;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hw_d     = hw_q;
    req_d    = req_q;
    addr_d   = addr_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    rvc_d    = rvc_q;
    mis_d    = mis_q;
    pc_ready = (state_q == IDLE) && !flush;
    sel_hw   = pc_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (state_q)
      IDLE: begin
        if (pc_valid && pc_ready) begin
          if (pc_i[0]) begin
            state_d = HOLD;
            inst_d  = '0;
            ipc_d   = pc_i;
            rvc_d   = 1'b0;
            mis_d   = 1'b1;
          end else begin
            state_d = LO;
            pc_d    = pc_i;
            req_d   = 1'b1;
            addr_d  = {pc_i[XLEN-1:2], 2'b00};
          end
        end
      end
      LO, HI: begin
        if (flush) begin
          if (mem_ack) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DRAIN;
          end
        end else if (mem_ack) begin
          state_d = HOLD;
          req_d   = 1'b0;
          ipc_d   = pc_q;
          mis_d   = 1'b0;
          rvc_d   = 1'b0;
          if (state_q == HI) begin
            inst_d = {mem_rdata[15:0], hw_q};
          end else if (sel_hw[1:0] != 2'b11) begin
            inst_d = {16'h0, sel_hw};
            rvc_d  = 1'b1;
          end else if (!pc_q[1]) begin
            inst_d = mem_rdata;
          end else begin
            // Upper halfword starts a 32-bit instruction: fetch the next word
            state_d = HI;
            req_d   = 1'b1;
            hw_d    = sel_hw;
            addr_d  = addr_q + XLEN'(4);
          end
        end
      end
      HOLD: begin
        if (flush || inst_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    valid_d = (state_d == HOLD);
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      hw_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      rvc_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hw_q    <= hw_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      rvc_q   <= rvc_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_req       = req_q;
  assign mem_addr      = addr_q;
  assign inst_valid    = valid_q;
  assign inst_o        = inst_q;
  assign inst_pc       = ipc_q;
  assign inst_rvc      = rvc_q;
  assign inst_misalign = mis_q;

endmodule

// File: tb/tb_ifetch_align.sv
// Bench for ifetch_align: directed scenarios plus random traffic, all checked
// against a transaction-level fetch model driven by a latency-randomised memory.
module tb_ifetch_align;
  localparam int unsigned XLEN = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            pc_valid = 1'b0;
  logic [XLEN-1:0] pc_i = '0;
  logic            pc_ready;
  logic            flush = 1'b0;
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack = 1'b0;
  logic [31:0]     mem_rdata = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst_o;
  logic [XLEN-1:0] inst_pc;
  logic            inst_rvc;
  logic            inst_misalign;

  ifetch_align #(.XLEN(XLEN), .MEM_LAT_MAX(0)) dut (
    .clock(clock), .reset(reset),
    .pc_valid(pc_valid), .pc_i(pc_i), .pc_ready(pc_ready), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_o(inst_o),
    .inst_pc(inst_pc), .inst_rvc(inst_rvc), .inst_misalign(inst_misalign)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: 64 words, indexed by address bits [7:2]
  logic [31:0] mem [64];
  int          lat_fixed = 0;
  int          lat_cnt = 0;
  bit          busy = 1'b0;

  function automatic logic [31:0] memw(input logic [XLEN-1:0] a);
    return mem[a[7:2]];
  endfunction

  always @(negedge clock) begin
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (!reset || !mem_req) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        busy    = 1'b1;
        lat_cnt = (lat_fixed < 0) ? int'($urandom_range(3, 0)) : lat_fixed;
      end
      if (lat_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = memw(mem_addr);
        busy      = 1'b0;
      end else begin
        lat_cnt--;
      end
    end
  end

  // Transaction-level model of one outstanding fetch
  bit              pend = 1'b0, drain = 1'b0;
  logic [XLEN-1:0] e_pc, drain_addr;
  logic [31:0]     e_inst;
  bit              e_rvc, e_mis;
  int              need, seen, age;

  function automatic void build(input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] base;
    logic [31:0]     w, w2;
    logic [15:0]     h;
    e_pc  = pc;
    e_rvc = 1'b0;
    e_mis = 1'b0;
    seen  = 0;
    if (pc[0]) begin
      e_mis  = 1'b1;
      e_inst = '0;
      need   = 0;
    end else begin
      base = pc & ~XLEN'(3);
      w    = memw(base);
      h    = pc[1] ? w[31:16] : w[15:0];
      if (h[1:0] != 2'b11) begin
        e_rvc  = 1'b1;
        e_inst = {16'h0, h};
        need   = 1;
      end else if (!pc[1]) begin
        e_inst = w;
        need   = 1;
      end else begin
        w2     = memw(base + XLEN'(4));
        e_inst = {w2[15:0], h};
        need   = 2;
      end
    end
  endfunction

  // Compare process: outputs at negedge+2, then model steps for the next edge
  initial begin
    bit              exp_valid, exp_req, exp_ready;
    logic [XLEN-1:0] exp_addr;
    forever begin
      @(negedge clock);
      #2;
      if (!reset) begin
        check("rst_mem_req", mem_req, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_outs", {inst_o, inst_pc, inst_rvc, inst_misalign, mem_addr}, 0);
        pend  = 1'b0;
        drain = 1'b0;
        age   = 0;
        continue;
      end
      exp_valid = pend && (seen == need);
      exp_req   = drain || (pend && seen < need);
      exp_addr  = drain ? drain_addr : (e_pc & ~XLEN'(3)) + XLEN'(4 * seen);
      exp_ready = !pend && !drain && !flush;
      check("inst_valid", inst_valid, exp_valid);
      check("mem_req", mem_req, exp_req);
      check("pc_ready", pc_ready, exp_ready);
      check("rvc_mis_excl", inst_rvc & inst_misalign, 0);
      check("addr_lsb", mem_addr[1:0], 0);
      if (mem_req && exp_req) check("mem_addr", mem_addr, exp_addr);
      if (inst_valid && exp_valid) begin
        check("inst_o", inst_o, e_inst);
        check("inst_pc", inst_pc, e_pc);
        check("inst_rvc", inst_rvc, e_rvc);
        check("inst_misalign", inst_misalign, e_mis);
      end
      age = (pend || drain) ? age + 1 : 0;
      if (age > 64) begin
        check("fetch_timeout", age, 0);
        pend  = 1'b0;
        drain = 1'b0;
        age   = 0;
      end
      if (pend) begin
        if (flush) begin
          if (exp_req && !mem_ack) begin
            drain      = 1'b1;
            drain_addr = exp_addr;
          end
          pend = 1'b0;
        end else if (exp_valid && inst_ready) begin
          pend = 1'b0;
          n_deliv++;
        end else if (mem_ack && seen < need) begin
          seen++;
        end
      end else if (drain) begin
        if (mem_ack) drain = 1'b0;
      end else if (exp_ready && pc_valid) begin
        build(pc_i);
        pend = 1'b1;
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic [XLEN-1:0] pc);
    bit acc = 1'b0;
    pc_valid = 1'b1;
    pc_i     = pc;
    for (int i = 0; i < 20 && !acc; i++) begin
      #2;
      acc = pc_ready;
      cyc();
    end
    pc_valid = 1'b0;
    check("issue_accept", 64'(acc), 1);
  endtask

  task automatic consume();
    cyc();
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
  endtask

  initial begin
    bit          got;
    logic [31:0] w;
    logic [31:0] r;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    cyc();
    cyc();

    // Aligned 32-bit, accepted on the first edge after reset release
    mem[0] = 32'h0050_0093;
    cyc();
    reset = 1'b1;
    issue(32'h100);
    #2;
    check("d039_req", mem_req, 1);
    check("d039_addr", mem_addr, 32'h100);
    cyc(); #2;
    check("d039_valid", inst_valid, 1);
    check("d039_inst", inst_o, 32'h0050_0093);
    check("d039_pc", inst_pc, 32'h100);
    check("d039_rvc", inst_rvc, 0);
    consume();

    // RVC in upper half, single request
    mem[0] = 32'h4505_0001;
    issue(32'h102);
    #2;
    check("d040_addr", mem_addr, 32'h100);
    cyc(); #2;
    check("d040_inst", inst_o, 32'h0000_4505);
    check("d040_rvc", inst_rvc, 1);
    check("d040_noreq", mem_req, 0);
    consume();

    // Split 32-bit across words
    mem[1] = 32'h0093_1234;
    mem[2] = 32'hABCD_0050;
    issue(32'h106);
    #2;
    check("d041_addr0", mem_addr, 32'h104);
    cyc(); #2;
    check("d041_addr1", mem_addr, 32'h108);
    cyc(); #2;
    check("d041_inst", inst_o, 32'h0050_0093);
    check("d041_pc", inst_pc, 32'h106);
    consume();

    // Misaligned PC
    issue(32'h101);
    #2;
    check("d042_noreq", mem_req, 0);
    check("d042_valid", inst_valid, 1);
    check("d042_mis", inst_misalign, 1);
    check("d042_inst", inst_o, 0);
    consume();

    // Flush while waiting on a slow ack
    lat_fixed = 3;
    mem[0]    = 32'h0050_0093;
    issue(32'h100);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      #2;
      check("d043_req_held", mem_req, 1);
      check("d043_no_valid", inst_valid, 0);
      got = mem_ack;
      if (!got) cyc();
    end
    check("d043_ack_seen", 64'(got), 1);
    cyc(); #2;
    check("d043_ready", pc_ready, 1);
    check("d043_req_off", mem_req, 0);
    cyc();
    lat_fixed = 0;

    // Flush coinciding with the ack discards the data
    issue(32'h100);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #2;
    check("d031_valid", inst_valid, 0);
    check("d031_ready", pc_ready, 1);
    cyc();

    // Wrap past the top of memory with a paused consumer
    mem[63] = 32'h0293_ABCD;
    mem[0]  = 32'h1234_0050;
    issue(32'hFFFF_FFFE);
    #2;
    check("d044_addr0", mem_addr, 32'hFFFF_FFFC);
    cyc(); #2;
    check("d044_addr1", mem_addr, 32'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      #2;
      check("d044_hold_valid", inst_valid, 1);
      check("d044_hold_inst", inst_o, 32'h0050_0293);
      check("d044_hold_pc", inst_pc, 32'hFFFF_FFFE);
      cyc();
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #2;
    check("d044_released", inst_valid, 0);
    cyc();

    // Reset in the middle of a fetch
    lat_fixed = 3;
    issue(32'h100);
    reset = 1'b0;
    #1;
    check("d037_req_drop", mem_req, 0);
    cyc();
    reset = 1'b1;
    cyc();

    // Random traffic
    lat_fixed = -1;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      case ($urandom_range(7, 0))
        0:       r[0] = 1'b1;
        1:       r = r | 32'hFFFF_FFF0 & ~32'h1;
        default: r[0] = 1'b0;
      endcase
      pc_valid   = ($urandom_range(1, 0) == 1);
      pc_i       = r;
      flush      = ($urandom_range(11, 0) == 0);
      inst_ready = ($urandom_range(1, 0) == 1);
      reset      = !(i >= 1500 && i < 1502);
      cyc();
    end
    pc_valid   = 1'b0;
    flush      = 1'b0;
    inst_ready = 1'b1;
    repeat (10) cyc();
    check("rand_delivered", 64'(n_deliv > 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_align.md
IFETCH_ALIGN -- requirements
Module: ifetch_align

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address/PC width.
REQ-002 The block SHALL have parameter MEM_LAT_MAX, default 0, meaning none; it is documentation only, and the memory ack latency is unbounded.
REQ-003 clock  input  1  rising-edge clock; one clock only.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 pc_valid  input  1  fetch address offered by the PC stage.
REQ-006 pc_i  input  XLEN  fetch address, byte granularity.
REQ-007 pc_ready  output  1  fetch address accepted this cycle.
REQ-008 flush  input  1  redirect: discard the current fetch and any buffered halfword.
REQ-009 mem_req  output  1  word read request to instruction memory.
REQ-010 mem_addr  output  XLEN  word-aligned read address, bits [1:0] always 0.
REQ-011 mem_ack  input  1  read complete; mem_rdata is valid in this cycle only.
REQ-012 mem_rdata  input  32  read data, little-endian.
REQ-013 inst_valid  output  1  instruction available.
REQ-014 inst_ready  input  1  consumer takes the instruction; 0 = pause.
REQ-015 inst_o  output  32  instruction; upper 16 bits are 0 for RVC.
REQ-016 inst_pc  output  XLEN  address of inst_o.
REQ-017 inst_rvc  output  1  inst_o is a 16-bit compressed instruction.
REQ-018 inst_misalign  output  1  fetch address had bit 0 set; inst_o is 0.

Function
REQ-019 The FSM SHALL have the states IDLE, LO, HI, HOLD, and DRAIN.
REQ-020 pc_ready SHALL equal 1 only in IDLE with flush=0; acceptance occurs when pc_valid & pc_ready.
REQ-021 On acceptance with pc_i[0]=0, the block SHALL capture pc_i and go to LO; mem_req=1 and mem_addr={pc[XLEN-1:2],2'b00} SHALL assert from the next cycle.
REQ-022 On acceptance with pc_i[0]=1, the block SHALL go to HOLD with inst_misalign=1, inst_o=0, and inst_pc=pc_i, with no memory access.
REQ-023 mem_req and mem_addr SHALL remain stable until mem_ack; mem_req SHALL drop in the cycle after the mem_ack cycle unless a new request follows.
REQ-024 LO with mem_ack, pc[1]=0: if rdata[1:0]!=2'b11, the block SHALL output an RVC instruction {16'h0, rdata[15:0]}; otherwise it SHALL output inst_o=rdata; the next state SHALL be HOLD.
REQ-025 LO with mem_ack, pc[1]=1, hw=rdata[31:16]: if hw[1:0]!=2'b11, the block SHALL output RVC {16'h0, hw} and go to HOLD; otherwise it SHALL save hw, go to HI, and set mem_addr = previous mem_addr + 4 (modulo 2^XLEN).
REQ-026 HI with mem_ack: inst_o SHALL equal {rdata[15:0], saved hw}, inst_rvc=0, and the next state SHALL be HOLD.
REQ-027 inst_valid SHALL equal 1 exactly in HOLD; inst_o, inst_pc, inst_rvc, and inst_misalign SHALL be registered and stable while in HOLD.
REQ-028 In HOLD, inst_ready=1 SHALL cause a transition to IDLE; the minimum initiation interval is therefore 3 cycles (aligned, ack in first request cycle).
REQ-029 Latency: mem_ack in cycle A SHALL give inst_valid=1 in cycle A+1.
REQ-030 flush in IDLE or HOLD SHALL force IDLE next cycle, drop inst_valid, and accept no pc that cycle.
REQ-031 flush in LO/HI with mem_ack=1 in the same cycle SHALL force IDLE and discard the data.
REQ-032 flush in LO/HI with mem_ack=0 SHALL go to DRAIN, keep mem_req/mem_addr asserted, and discard the data on mem_ack, then go to IDLE.
REQ-033 Any flush during DRAIN SHALL leave the block in DRAIN.
REQ-034 In HOLD with flush=1 and inst_ready=1 together, flush SHALL win and the instruction SHALL be discarded.
REQ-035 inst_rvc and inst_misalign SHALL never both be 1.

Reset
REQ-036 Reset SHALL asynchronously force state IDLE, saved hw=0, mem_req=0, mem_addr=0, inst_valid=0, inst_o=0, inst_pc=0, inst_rvc=0, and inst_misalign=0.
REQ-037 Reset mid-fetch SHALL abandon the request immediately; mem_req=0 while reset is low.
REQ-038 The first acceptance after reset release SHALL be possible in the first rising edge with reset high.

Verification
REQ-039 Aligned 32-bit: pc_i=0x100, ack next cycle, rdata=0x00500093 -> mem_addr=0x100, inst_o=0x00500093, inst_pc=0x100, inst_rvc=0.
REQ-040 RVC upper half: pc_i=0x102, rdata=0x4505_0001 -> inst_o=0x00004505, inst_rvc=1, single request.
REQ-041 Split 32-bit: pc_i=0x106, rdata@0x104=0x0093_xxxx, rdata@0x108=0xyyyy_0050 -> mem_addr 0x104 then 0x108, inst_o=0x00500093, inst_pc=0x106.
REQ-042 Misaligned: pc_i=0x101 -> mem_req stays 0, next cycle inst_valid=1, inst_misalign=1, inst_o=0.
REQ-043 Flush while waiting: mem_ack delayed 3 cycles, flush on cycle 1 -> mem_req held until ack, no inst_valid, pc_ready=1 in the cycle after ack.
REQ-044 Pause and wrap: pc_i=0xFFFF_FFFE with 32-bit hw, inst_ready=0 for 4 cycles -> second mem_addr=0x0000_0000, outputs stable in HOLD until inst_ready=1.
